hazard_ctrl: RTL and testbench

Pipeline hazard scheduler for the five-stage MIPS core. It consumes the per-instruction Tuse/Tnew/destination information produced by the decoder in the D stage. It keeps shadow copies of destination register and remaining Tnew for the instructions in E, M and W. From these it drives the pipeline stall/bubble and all forwarding-mux selects. It also keeps a saturating stall-cycle counter for performance debug.

---
 rtl/hazard_pkg.sv | 51 +++++
 rtl/hazard_match.sv | 16 +
 rtl/hazard_ctrl.sv | 160 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard scheduler.
// Forward-select codes, stage shadow layout, Tnew ageing.
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_W  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] a3;
    logic [1:0] tnew;
    logic       tuse_rt2;
  } shadow_t;

  function automatic logic [1:0] tnew_dec(
    input logic [1:0] t
  );
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // Operand needed before the producer has its result.
  function automatic logic need_stall(
    input logic       hit,
    input logic       rdy,
    input logic [1:0] tnew,
    input logic       t0,
    input logic       t1,
    input logic       t2
  );
    return hit && !rdy &&
      (t0 || (t1 && tnew > 2'd1) ||
       (t2 && tnew > 2'd2));
  endfunction

  // Nearest stage wins; an unready M match blocks W.
  function automatic logic [1:0] fwd_sel(
    input logic m_hit,
    input logic m_rdy,
    input logic w_hit,
    input logic w_rdy
  );
    if (m_hit)
      return m_rdy ? FWD_M : FWD_RF;
    if (w_hit && w_rdy)
      return FWD_W;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Compare one source register against one stage shadow.
// match ignores $0; ready means the stage result exists.
module hazard_match
  import hazard_pkg::*;
(
  input  logic [4:0] src,
  input  logic [4:0] a3,
  input  logic [1:0] tnew,
  output logic       match,
  output logic       ready
);

  assign match = (src == a3) && (a3 != 5'd0);
  assign ready = (tnew == 2'd0);

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage MIPS hazard scheduler: stall, bubble and
// forwarding selects from shadow E/M/W destination info.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       d_rs,
  input  logic [4:0]       d_rt,
  input  logic             d_tuse_rs0,
  input  logic             d_tuse_rs1,
  input  logic             d_tuse_rt0,
  input  logic             d_tuse_rt1,
  input  logic             d_tuse_rt2,
  input  logic             d_regwrite,
  input  logic [4:0]       d_a3,
  input  logic [1:0]       d_tnew,
  output logic             stall,
  output logic [1:0]       fwd_d_rs,
  output logic [1:0]       fwd_d_rt,
  output logic [1:0]       fwd_e_rs,
  output logic [1:0]       fwd_e_rt,
  output logic             fwd_m_rt,
  output logic [CNT_W-1:0] stall_cnt
);

  shadow_t    e_q;
  shadow_t    e_d;
  logic [4:0] m_rt;
  logic [4:0] m_a3;
  logic [1:0] m_tnew;
  logic       m_rt2;
  logic [4:0] w_a3;

  logic drs_e_hit, drs_e_rdy;
  logic drs_m_hit, drs_m_rdy;
  logic drs_w_hit, drs_w_rdy;
  logic drt_e_hit, drt_e_rdy;
  logic drt_m_hit, drt_m_rdy;
  logic drt_w_hit, drt_w_rdy;
  logic ers_m_hit, ers_m_rdy;
  logic ers_w_hit, ers_w_rdy;
  logic ert_m_hit, ert_m_rdy;
  logic ert_w_hit, ert_w_rdy;
  logic mrt_w_hit, mrt_w_rdy;

  logic stall_rs;
  logic stall_rt;

  hazard_match u_drs_e (
    .src(d_rs), .a3(e_q.a3), .tnew(e_q.tnew),
    .match(drs_e_hit), .ready(drs_e_rdy)
  );
  hazard_match u_drs_m (
    .src(d_rs), .a3(m_a3), .tnew(m_tnew),
    .match(drs_m_hit), .ready(drs_m_rdy)
  );
  hazard_match u_drs_w (
    .src(d_rs), .a3(w_a3), .tnew(2'd0),
    .match(drs_w_hit), .ready(drs_w_rdy)
  );
  hazard_match u_drt_e (
    .src(d_rt), .a3(e_q.a3), .tnew(e_q.tnew),
    .match(drt_e_hit), .ready(drt_e_rdy)
  );
  hazard_match u_drt_m (
    .src(d_rt), .a3(m_a3), .tnew(m_tnew),
    .match(drt_m_hit), .ready(drt_m_rdy)
  );
  hazard_match u_drt_w (
    .src(d_rt), .a3(w_a3), .tnew(2'd0),
    .match(drt_w_hit), .ready(drt_w_rdy)
  );
  hazard_match u_ers_m (
    .src(e_q.rs), .a3(m_a3), .tnew(m_tnew),
    .match(ers_m_hit), .ready(ers_m_rdy)
  );
  hazard_match u_ers_w (
    .src(e_q.rs), .a3(w_a3), .tnew(2'd0),
    .match(ers_w_hit), .ready(ers_w_rdy)
  );
  hazard_match u_ert_m (
    .src(e_q.rt), .a3(m_a3), .tnew(m_tnew),
    .match(ert_m_hit), .ready(ert_m_rdy)
  );
  hazard_match u_ert_w (
    .src(e_q.rt), .a3(w_a3), .tnew(2'd0),
    .match(ert_w_hit), .ready(ert_w_rdy)
  );
  hazard_match u_mrt_w (
    .src(m_rt), .a3(w_a3), .tnew(2'd0),
    .match(mrt_w_hit), .ready(mrt_w_rdy)
  );

  always_comb begin
    stall_rs =
      need_stall(drs_e_hit, drs_e_rdy, e_q.tnew,
                 d_tuse_rs0, d_tuse_rs1, 1'b0) |
      need_stall(drs_m_hit, drs_m_rdy, m_tnew,
                 d_tuse_rs0, d_tuse_rs1, 1'b0);
    stall_rt =
      need_stall(drt_e_hit, drt_e_rdy, e_q.tnew,
                 d_tuse_rt0, d_tuse_rt1, d_tuse_rt2) |
      need_stall(drt_m_hit, drt_m_rdy, m_tnew,
                 d_tuse_rt0, d_tuse_rt1, d_tuse_rt2);
    stall = stall_rs | stall_rt;
  end

  always_comb begin
    fwd_d_rs = fwd_sel(drs_m_hit, drs_m_rdy,
                       drs_w_hit, drs_w_rdy);
    fwd_d_rt = fwd_sel(drt_m_hit, drt_m_rdy,
                       drt_w_hit, drt_w_rdy);
    fwd_e_rs = fwd_sel(ers_m_hit, ers_m_rdy,
                       ers_w_hit, ers_w_rdy);
    fwd_e_rt = fwd_sel(ert_m_hit, ert_m_rdy,
                       ert_w_hit, ert_w_rdy);
    fwd_m_rt = m_rt2 && mrt_w_hit && mrt_w_rdy;
  end

  // Non-writers are folded to a3=0 so they never match.
  always_comb begin
    e_d = '0;
    if (!stall) begin
      e_d.rs       = d_rs;
      e_d.rt       = d_rt;
      e_d.a3       = d_regwrite ? d_a3 : 5'd0;
      e_d.tnew     = d_regwrite ? d_tnew : 2'd0;
      e_d.tuse_rt2 = d_tuse_rt2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q    <= '0;
      m_rt   <= '0;
      m_a3   <= '0;
      m_tnew <= '0;
      m_rt2  <= 1'b0;
      w_a3   <= '0;
    end else begin
      e_q    <= e_d;
      m_rt   <= e_q.rt;
      m_a3   <= e_q.a3;
      m_tnew <= tnew_dec(e_q.tnew);
      m_rt2  <= e_q.tuse_rt2;
      w_a3   <= m_a3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (stall && !(&stall_cnt))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: stimulus pushes expected
// outputs into a queue, a negedge monitor pops and compares.
module tb_hazard_ctrl;

  // Narrow counter keeps the saturation run short.
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4:0]    d_rs = '0;
  logic [4:0]    d_rt = '0;
  logic          d_tuse_rs0 = 1'b0;
  logic          d_tuse_rs1 = 1'b0;
  logic          d_tuse_rt0 = 1'b0;
  logic          d_tuse_rt1 = 1'b0;
  logic          d_tuse_rt2 = 1'b0;
  logic          d_regwrite = 1'b0;
  logic [4:0]    d_a3 = '0;
  logic [1:0]    d_tnew = '0;
  logic          stall;
  logic [1:0]    fwd_d_rs, fwd_d_rt;
  logic [1:0]    fwd_e_rs, fwd_e_rt;
  logic          fwd_m_rt;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .d_rs(d_rs), .d_rt(d_rt),
    .d_tuse_rs0(d_tuse_rs0), .d_tuse_rs1(d_tuse_rs1),
    .d_tuse_rt0(d_tuse_rt0), .d_tuse_rt1(d_tuse_rt1),
    .d_tuse_rt2(d_tuse_rt2),
    .d_regwrite(d_regwrite), .d_a3(d_a3),
    .d_tnew(d_tnew),
    .stall(stall),
    .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
    .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt),
    .fwd_m_rt(fwd_m_rt),
    .stall_cnt(stall_cnt)
  );

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       trs0, trs1, trt0, trt1, trt2;
    logic       rw;
    logic [4:0] a3;
    logic [1:0] tnew;
  } dv_t;

  typedef struct packed {
    logic          st;
    logic [1:0]    drs, drt, ers, ert;
    logic          mrt;
    logic [CW-1:0] cnt;
  } ex_t;

  ex_t           exp_q[$];
  string         tag_q[$];
  int            total = 0;
  int            bad = 0;
  logic [CW-1:0] exp_cnt = '0;
  ex_t           mon_e, mon_a;
  string         mon_t;

  function automatic dv_t nop();
    return '0;
  endfunction

  function automatic dv_t wr(
    input logic [4:0] a3, input logic rw,
    input logic [1:0] tn
  );
    dv_t v = '0;
    v.trs1 = 1'b1; v.rw = rw; v.a3 = a3; v.tnew = tn;
    return v;
  endfunction

  function automatic dv_t alu(input logic [4:0] a3);
    return wr(a3, 1'b1, 2'd1);
  endfunction

  function automatic dv_t ld(input logic [4:0] a3);
    return wr(a3, 1'b1, 2'd2);
  endfunction

  function automatic dv_t add(
    input logic [4:0] rs, input logic [4:0] rt,
    input logic [4:0] a3
  );
    dv_t v = '0;
    v.rs = rs; v.rt = rt; v.trs1 = 1'b1; v.trt1 = 1'b1;
    v.rw = 1'b1; v.a3 = a3; v.tnew = 2'd1;
    return v;
  endfunction

  function automatic dv_t br(
    input logic [4:0] rs, input logic [4:0] rt
  );
    dv_t v = '0;
    v.rs = rs; v.rt = rt; v.trs0 = 1'b1; v.trt0 = 1'b1;
    return v;
  endfunction

  function automatic dv_t sw(input logic [4:0] rt);
    dv_t v = '0;
    v.rt = rt; v.trs1 = 1'b1; v.trt2 = 1'b1;
    return v;
  endfunction

  function automatic ex_t ex(
    input logic st, input logic [1:0] drs,
    input logic [1:0] drt, input logic [1:0] ers,
    input logic [1:0] ert, input logic mrt
  );
    ex_t e = '0;
    e.st = st; e.drs = drs; e.drt = drt;
    e.ers = ers; e.ert = ert; e.mrt = mrt;
    return e;
  endfunction

  task automatic step(
    input string tag, input logic r,
    input dv_t v, input ex_t e
  );
    @(posedge clk);
    #1;
    rst_n = r;
    d_rs = v.rs; d_rt = v.rt;
    d_tuse_rs0 = v.trs0; d_tuse_rs1 = v.trs1;
    d_tuse_rt0 = v.trt0; d_tuse_rt1 = v.trt1;
    d_tuse_rt2 = v.trt2;
    d_regwrite = v.rw; d_a3 = v.a3; d_tnew = v.tnew;
    if (!r) exp_cnt = '0;
    e.cnt = exp_cnt;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    if (r && e.st && exp_cnt != {CW{1'b1}})
      exp_cnt = exp_cnt + 1'b1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      mon_a = {stall, fwd_d_rs, fwd_d_rt,
               fwd_e_rs, fwd_e_rt, fwd_m_rt, stall_cnt};
      total++;
      if (mon_a !== mon_e) begin
        bad++;
        $display("FAIL %s: got st=%0d d=%0d/%0d e=%0d/%0d m=%0d cnt=%0d need st=%0d d=%0d/%0d e=%0d/%0d m=%0d cnt=%0d",
          mon_t, mon_a.st, mon_a.drs, mon_a.drt,
          mon_a.ers, mon_a.ert, mon_a.mrt, mon_a.cnt,
          mon_e.st, mon_e.drs, mon_e.drt,
          mon_e.ers, mon_e.ert, mon_e.mrt, mon_e.cnt);
      end
    end
  end

  initial begin
    ex_t z;
    ex_t s;
    z = ex(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    s = ex(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);

    step("rst_a", 1'b0, add(5'd8, 5'd9, 5'd10), z);
    step("rst_b", 1'b0, br(5'd3, 5'd4), z);
    for (int i = 0; i < 3; i++)
      step("nop", 1'b1, nop(), z);

    step("aa_p", 1'b1, alu(5'd8), z);
    step("aa_c", 1'b1, add(5'd8, 5'd7, 5'd13), z);
    step("aa_fe", 1'b1, nop(),
         ex(1'b0, 2'd0, 2'd0, 2'd2, 2'd0, 1'b0));
    step("aa_t1", 1'b1, nop(), z);
    step("aa_t2", 1'b1, nop(), z);

    step("a1_p", 1'b1, alu(5'd8), z);
    step("a1_n", 1'b1, nop(), z);
    step("a1_c", 1'b1, add(5'd8, 5'd7, 5'd13),
         ex(1'b0, 2'd2, 2'd0, 2'd0, 2'd0, 1'b0));
    step("a1_fe", 1'b1, nop(),
         ex(1'b0, 2'd0, 2'd0, 2'd1, 2'd0, 1'b0));
    step("a1_t1", 1'b1, nop(), z);
    step("a1_t2", 1'b1, nop(), z);

    step("lu_p", 1'b1, ld(5'd9), z);
    step("lu_s", 1'b1, add(5'd9, 5'd7, 5'd13), s);
    step("lu_c", 1'b1, add(5'd9, 5'd7, 5'd13), z);
    step("lu_fe", 1'b1, nop(),
         ex(1'b0, 2'd0, 2'd0, 2'd1, 2'd0, 1'b0));
    step("lu_t1", 1'b1, nop(), z);
    step("lu_t2", 1'b1, nop(), z);

    step("lb_p", 1'b1, ld(5'd9), z);
    step("lb_s1", 1'b1, br(5'd9, 5'd7), s);
    step("lb_s2", 1'b1, br(5'd9, 5'd7), s);
    step("lb_fd", 1'b1, br(5'd9, 5'd7),
         ex(1'b0, 2'd1, 2'd0, 2'd0, 2'd0, 1'b0));
    step("lb_t1", 1'b1, nop(), z);
    step("lb_t2", 1'b1, nop(), z);

    step("ob_p", 1'b1, alu(5'd10), z);
    step("ob_s", 1'b1, br(5'd7, 5'd10), s);
    step("ob_fd", 1'b1, br(5'd7, 5'd10),
         ex(1'b0, 2'd0, 2'd2, 2'd0, 2'd0, 1'b0));
    step("ob_fe", 1'b1, nop(),
         ex(1'b0, 2'd0, 2'd0, 2'd0, 2'd1, 1'b0));
    step("ob_t", 1'b1, nop(), z);

    step("sd_p", 1'b1, ld(5'd11), z);
    step("sd_c", 1'b1, sw(5'd11), z);
    step("sd_e", 1'b1, nop(), z);
    step("sd_fm", 1'b1, nop(),
         ex(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1));
    step("sd_t", 1'b1, nop(), z);

    step("r0_p", 1'b1, wr(5'd0, 1'b1, 2'd2), z);
    step("r0_c1", 1'b1, br(5'd0, 5'd0), z);
    step("r0_c2", 1'b1, br(5'd0, 5'd0), z);
    step("r0_c3", 1'b1, br(5'd0, 5'd0), z);
    step("nw_p", 1'b1, wr(5'd12, 1'b0, 2'd2), z);
    step("nw_c", 1'b1, br(5'd12, 5'd0), z);
    step("nw_e", 1'b1, nop(), z);
    step("nw_t", 1'b1, nop(), z);

    step("em_p1", 1'b1, alu(5'd12), z);
    step("em_p2", 1'b1, alu(5'd12), z);
    step("em_c", 1'b1, add(5'd12, 5'd7, 5'd13),
         ex(1'b0, 2'd2, 2'd0, 2'd0, 2'd0, 1'b0));
    step("em_fe", 1'b1, nop(),
         ex(1'b0, 2'd0, 2'd0, 2'd2, 2'd0, 1'b0));
    step("em_t1", 1'b1, nop(), z);
    step("em_t2", 1'b1, nop(), z);

    step("rm_p", 1'b1, ld(5'd9), z);
    step("rm_s", 1'b1, br(5'd9, 5'd0), s);
    step("rm_rst", 1'b0, br(5'd9, 5'd0), z);
    step("rm_t1", 1'b1, nop(), z);
    step("rm_t2", 1'b1, nop(), z);

    for (int k = 0; k < 560; k++) begin
      step("sat_p", 1'b1, ld(5'd9), z);
      step("sat_s1", 1'b1, br(5'd9, 5'd0), s);
      step("sat_s2", 1'b1, br(5'd9, 5'd0), s);
    end
    step("sat_t1", 1'b1, nop(), z);
    step("sat_t2", 1'b1, nop(), z);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++)
      @(posedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending need 0",
               exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
